param_io_ram: RTL

PARAM_IO_RAM -- requirements
Module: param_io_ram

---
 rtl/cpu15_pkg.sv | 29 ++
 rtl/io_sync2.sv | 32 +++
 rtl/param_io_ram.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu15_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu15_pkg
//  Description : Shared FSM state codes, read-source codes and I/O address
//                decode helpers for the CPU15 data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu15_pkg;

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    // Which registered source drives RAM_OUT in the cycle after a read.
    localparam logic [1:0] c_SRC_ZERO = 2'd0;
    localparam logic [1:0] c_SRC_RAM  = 2'd1;
    localparam logic [1:0] c_SRC_IO   = 2'd2;

    localparam int c_MAX_NUM_IO = 8;

    function automatic int io_out_addr(input int base, input int k);
        return base + 2 * k;
    endfunction

    function automatic int io_in_addr(input int base, input int k);
        return base + 2 * k + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : io_sync2
//  Description : Two-flop synchroniser for one asynchronous input port.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/param_io_ram.sv
`default_nettype none
// ============================================================================
//  Module      : param_io_ram
//  Description : Single-port data RAM with memory-mapped output/input port
//                pairs and a zero-fill sweep after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_io_ram
    import cpu15_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int NUM_IO  = 1,
    parameter int IO_BASE = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLK_EX,
    input  logic [ADDR_W-1:0]        RAM_ADDR,
    input  logic [DATA_W-1:0]        RAM_IN,
    input  logic                     RAM_WEN,
    input  logic [NUM_IO*DATA_W-1:0] IO_IN,
    output logic [DATA_W-1:0]        RAM_OUT,
    output logic [NUM_IO*DATA_W-1:0] IO_OUT,
    output logic [NUM_IO-1:0]        IO_OUT_STB,
    output logic                     RAM_READY
);

    localparam int              c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

    logic [0:0]               r_state;
    logic [ADDR_W-1:0]        r_clr_addr;
    logic [DATA_W-1:0]        r_mem [c_DEPTH];
    logic [DATA_W-1:0]        r_mem_q;
    logic [DATA_W-1:0]        r_io_q;
    logic [1:0]               r_src;
    logic [NUM_IO*DATA_W-1:0] r_io_out;
    logic [NUM_IO-1:0]        r_stb;

    logic [NUM_IO*DATA_W-1:0] w_sync;
    logic [NUM_IO-1:0]        w_out_hit;
    logic [NUM_IO-1:0]        w_in_hit;
    logic [DATA_W-1:0]        w_io_rd;
    logic                     w_ready;
    logic                     w_clearing;
    logic                     w_wr;
    logic                     w_is_io;
    logic                     w_mem_we;
    logic [ADDR_W-1:0]        w_mem_addr;
    logic [DATA_W-1:0]        w_mem_wdata;

    generate
        for (genvar k = 0; k < NUM_IO; k++) begin : g_sync
            io_sync2 #(
                .WIDTH (DATA_W)
            ) u_sync (
                .clk (CLK),
                .rst (RST),
                .i_d (IO_IN[k*DATA_W +: DATA_W]),
                .o_q (w_sync[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign w_ready    = (r_state == c_ST_RUN);
    assign w_clearing = (r_state == c_ST_CLEAR);
    assign w_wr       = RAM_WEN & CLK_EX & w_ready;
    assign w_is_io    = (|w_out_hit) | (|w_in_hit);

    // I/O decode; a write-first bypass makes an output-port read see RAM_IN.
    always_comb begin
        w_out_hit = '0;
        w_in_hit  = '0;
        w_io_rd   = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (RAM_ADDR == ADDR_W'(io_out_addr(IO_BASE, k))) begin
                w_out_hit[k] = 1'b1;
                w_io_rd      = w_wr ? RAM_IN : r_io_out[k*DATA_W +: DATA_W];
            end
            if (RAM_ADDR == ADDR_W'(io_in_addr(IO_BASE, k))) begin
                w_in_hit[k] = 1'b1;
                w_io_rd     = w_sync[k*DATA_W +: DATA_W];
            end
        end
    end

    // The clear sweep and CPU writes share the single RAM write port.
    assign w_mem_we    = ~RST & (w_clearing | (w_wr & ~w_is_io));
    assign w_mem_addr  = w_clearing ? r_clr_addr : RAM_ADDR;
    assign w_mem_wdata = w_clearing ? '0 : RAM_IN;

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
            r_mem_q           <= w_mem_wdata;
        end else begin
            r_mem_q <= r_mem[RAM_ADDR];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_ST_CLEAR;
            r_clr_addr <= '0;
        end else if (w_clearing) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (r_clr_addr == c_LAST) begin
                r_state <= c_ST_RUN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_io_out <= '0;
            r_stb    <= '0;
            r_src    <= c_SRC_ZERO;
            r_io_q   <= '0;
        end else begin
            r_stb  <= w_wr ? w_out_hit : '0;
            r_io_q <= w_io_rd;
            for (int k = 0; k < NUM_IO; k++) begin
                if (w_wr && w_out_hit[k]) begin
                    r_io_out[k*DATA_W +: DATA_W] <= RAM_IN;
                end
            end
            if (!w_ready) begin
                r_src <= c_SRC_ZERO;
            end else if (w_is_io) begin
                r_src <= c_SRC_IO;
            end else begin
                r_src <= c_SRC_RAM;
            end
        end
    end

    always_comb begin
        RAM_OUT = '0;
        case (r_src)
            c_SRC_RAM: RAM_OUT = r_mem_q;
            c_SRC_IO:  RAM_OUT = r_io_q;
            default:   RAM_OUT = '0;
        endcase
    end

    assign IO_OUT     = r_io_out;
    assign IO_OUT_STB = r_stb;
    assign RAM_READY  = w_ready;

endmodule
`default_nettype wire
